// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multi-cycle ARM controller.
// Holds the FSM state enum, datapath select codes and the data-processing cmd decoder.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  typedef struct packed {
    logic [2:0] alu;
    logic       wr;
    logic       supported;
    logic       nz_only;
  } dp_ctl_t;

  // Unsupported commands degrade to an ADD with no register or flag side effects.
  function automatic dp_ctl_t decode_cmd(input logic [3:0] cmd);
    dp_ctl_t c;
    c = '{alu: ALU_ADD, wr: 1'b0, supported: 1'b0, nz_only: 1'b0};
    case (cmd)
      CMD_ADD: c = '{alu: ALU_ADD, wr: 1'b1, supported: 1'b1, nz_only: 1'b0};
      CMD_SUB: c = '{alu: ALU_SUB, wr: 1'b1, supported: 1'b1, nz_only: 1'b0};
      CMD_AND: c = '{alu: ALU_AND, wr: 1'b1, supported: 1'b1, nz_only: 1'b1};
      CMD_ORR: c = '{alu: ALU_ORR, wr: 1'b1, supported: 1'b1, nz_only: 1'b1};
      CMD_CMP: c = '{alu: ALU_SUB, wr: 1'b0, supported: 1'b1, nz_only: 1'b0};
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_cond.sv
// Condition unit: NZCV flags register, partial (NZ-only) update and cond-field evaluation.
// cond_ex_o is combinational from the registered flags; flags update on the clock edge.
module arm_cond_unit
  import arm_mc_pkg::*;
#(
  parameter int unsigned COND_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_we_i,
  input  logic       nz_only_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;
  logic       cond_raw;

  assign {n, z, c, v} = flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_we_i) begin
      if (nz_only_i) flags_d = {alu_flags_i[3:2], flags_q[1:0]};
      else           flags_d = alu_flags_i;
    end
  end

  always_comb begin
    cond_raw = 1'b0;
    case (cond_i)
      COND_EQ: cond_raw = z;
      COND_NE: cond_raw = ~z;
      COND_CS: cond_raw = c;
      COND_CC: cond_raw = ~c;
      COND_MI: cond_raw = n;
      COND_PL: cond_raw = ~n;
      COND_VS: cond_raw = v;
      COND_VC: cond_raw = ~v;
      COND_HI: cond_raw = c & ~z;
      COND_LS: cond_raw = ~c | z;
      COND_GE: cond_raw = (n == v);
      COND_LT: cond_raw = (n != v);
      COND_GT: cond_raw = ~z & (n == v);
      COND_LE: cond_raw = z | (n != v);
      COND_AL: cond_raw = 1'b1;
      default: cond_raw = 1'b0;
    endcase
  end

  assign cond_ex_o = (COND_EN != 0) ? cond_raw : 1'b1;

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multi-cycle ARM controller: start-gated FSM sequencing fetch/decode/execute/writeback
// over one memory port, with MEM_WAIT extra cycles per memory access.
module arm_multicycle_ctrl
  import arm_mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned COND_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        ByteMem,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUControl,
  output logic        busy
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  dp_ctl_t    dp;
  logic       cond_ex;
  logic       mem_last;
  logic       flag_we;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  assign dp        = decode_cmd(funct[4:1]);
  assign mem_last  = (wait_q == WAIT_LAST);

  assign flag_we = (state_q == S_ALUWB) && dp.supported &&
                   (funct[0] || (funct[4:1] == CMD_CMP));

  arm_cond_unit #(.COND_EN(COND_EN)) u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (cond),
    .alu_flags_i (ALUFlags),
    .flag_we_i   (flag_we),
    .nz_only_i   (dp.nz_only),
    .cond_ex_o   (cond_ex)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    wait_d = 4'd0;
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !mem_last)
      wait_d = wait_q + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (mem_last) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        if (cond_ex) begin
          case (op)
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_last) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_last) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    ByteMem    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ImmSrc     = IMM_8;
    RegSrc     = 2'b00;
    ALUControl = ALU_ADD;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_last;
        PCWrite   = mem_last;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        case (op)
          OP_MEM: begin
            ImmSrc = IMM_12;
            RegSrc = {~funct[0], 1'b0};
          end
          OP_BR: begin
            ImmSrc = IMM_24;
            RegSrc = 2'b01;
          end
          default: ;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_12;
        RegSrc  = {~funct[0], 1'b0};
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        ByteMem = funct[2];
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        ByteMem  = funct[2];
        RegSrc   = 2'b10;
        MemWrite = mem_last;
      end
      S_EXECR: ALUControl = dp.alu;
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dp.alu;
      end
      // ALU operands stay as in EXEC so ALUFlags still reflect this instruction.
      S_ALUWB: begin
        ALUSrcB    = funct[5] ? SRCB_IMM : SRCB_RD2;
        ALUControl = dp.alu;
        RegWrite   = dp.wr;
        PCWrite    = dp.wr && (rd == 4'hF);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_24;
        RegSrc    = 2'b01;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: three instances (MEM_WAIT 0/2/3, COND_EN 1/1/0)
// share inputs; only one is out of reset at a time.
module tb_arm_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic        start;
  logic [19:0] instr;
  logic [3:0]  alu_flags;

  int checks   = 0;
  int failures = 0;

  logic pcw_a, adr_a, mw_a, bm_a, irw_a, rw_a, sa_a, busy_a;
  logic pcw_b, adr_b, mw_b, bm_b, irw_b, rw_b, sa_b, busy_b;
  logic pcw_c, adr_c, mw_c, bm_c, irw_c, rw_c, sa_c, busy_c;
  logic [1:0] res_a, sb_a, imm_a, rs_a;
  logic [1:0] res_b, sb_b, imm_b, rs_b;
  logic [1:0] res_c, sb_c, imm_c, rs_c;
  logic [2:0] alu_a, alu_b, alu_c;
  logic [18:0] sig_a, sig_b, sig_c;

  always #5 clk = ~clk;

  arm_multicycle_ctrl #(.MEM_WAIT(0), .COND_EN(1)) u_a (
    .clk(clk), .reset(rst_a), .start(start), .Instr(instr), .ALUFlags(alu_flags),
    .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .ByteMem(bm_a), .IRWrite(irw_a),
    .RegWrite(rw_a), .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a),
    .RegSrc(rs_a), .ALUControl(alu_a), .busy(busy_a));

  arm_multicycle_ctrl #(.MEM_WAIT(2), .COND_EN(1)) u_b (
    .clk(clk), .reset(rst_b), .start(start), .Instr(instr), .ALUFlags(alu_flags),
    .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .ByteMem(bm_b), .IRWrite(irw_b),
    .RegWrite(rw_b), .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b),
    .RegSrc(rs_b), .ALUControl(alu_b), .busy(busy_b));

  arm_multicycle_ctrl #(.MEM_WAIT(3), .COND_EN(0)) u_c (
    .clk(clk), .reset(rst_c), .start(start), .Instr(instr), .ALUFlags(alu_flags),
    .PCWrite(pcw_c), .AdrSrc(adr_c), .MemWrite(mw_c), .ByteMem(bm_c), .IRWrite(irw_c),
    .RegWrite(rw_c), .ResultSrc(res_c), .ALUSrcA(sa_c), .ALUSrcB(sb_c), .ImmSrc(imm_c),
    .RegSrc(rs_c), .ALUControl(alu_c), .busy(busy_c));

  assign sig_a = {pcw_a, adr_a, mw_a, bm_a, irw_a, rw_a, res_a, sa_a, sb_a, imm_a, rs_a, alu_a, busy_a};
  assign sig_b = {pcw_b, adr_b, mw_b, bm_b, irw_b, rw_b, res_b, sa_b, sb_b, imm_b, rs_b, alu_b, busy_b};
  assign sig_c = {pcw_c, adr_c, mw_c, bm_c, irw_c, rw_c, res_c, sa_c, sb_c, imm_c, rs_c, alu_c, busy_c};

  function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic bm, input logic irw, input logic rw,
                                     input logic [1:0] res, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [1:0] rs,
                                     input logic [2:0] alu, input logic bz);
    return {pcw, adr, mw, bm, irw, rw, res, sa, sb, imm, rs, alu, bz};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [18:0] F_LAST, F_WAIT, D_DP, D_ST, D_LD, D_BR, MA_ST, MA_LD;
  logic [18:0] MWB_WAIT, MWB_LAST, MWW_WAIT, MWW_LAST, MR_B, MWB;
  logic [18:0] EXR_ADD, WB_ADD, EXI_SUB, WB_SUBI, WB_CMPI, EXR_AND, WB_AND, WB_ADDPC, BR;

  initial begin
    F_LAST   = mk(1,0,0,0,1,0,2'b10,1,2'b10,2'b00,2'b00,3'b000,1);
    F_WAIT   = mk(0,0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,3'b000,1);
    D_DP     = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00,3'b000,1);
    D_ST     = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b01,2'b10,3'b000,1);
    D_LD     = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b01,2'b00,3'b000,1);
    D_BR     = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b10,2'b01,3'b000,1);
    MA_ST    = mk(0,0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b10,3'b000,1);
    MA_LD    = mk(0,0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,3'b000,1);
    MWB_WAIT = mk(0,1,0,1,0,0,2'b00,0,2'b00,2'b00,2'b10,3'b000,1);
    MWB_LAST = mk(0,1,1,1,0,0,2'b00,0,2'b00,2'b00,2'b10,3'b000,1);
    MWW_WAIT = mk(0,1,0,0,0,0,2'b00,0,2'b00,2'b00,2'b10,3'b000,1);
    MWW_LAST = mk(0,1,1,0,0,0,2'b00,0,2'b00,2'b00,2'b10,3'b000,1);
    MR_B     = mk(0,1,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000,1);
    MWB      = mk(0,0,0,0,0,1,2'b01,0,2'b00,2'b00,2'b00,3'b000,1);
    EXR_ADD  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000,1);
    WB_ADD   = mk(0,0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,3'b000,1);
    EXI_SUB  = mk(0,0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,3'b001,1);
    WB_SUBI  = mk(0,0,0,0,0,1,2'b00,0,2'b01,2'b00,2'b00,3'b001,1);
    WB_CMPI  = mk(0,0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,3'b001,1);
    EXR_AND  = mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b010,1);
    WB_AND   = mk(0,0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,3'b010,1);
    WB_ADDPC = mk(1,0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,3'b000,1);
    BR       = mk(1,0,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,3'b000,1);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start = 1'b0; instr = 20'h0; alu_flags = 4'h0;
    step(); step();

    // ---- instance A: MEM_WAIT=0, COND_EN=1 ----
    chk("reset_sig", 32'(sig_a), 32'h0);
    chk("reset_flags", 32'(u_a.u_cond.flags_q), 32'h0);
    chk("reset_wait", 32'(u_a.wait_q), 32'h0);
    #3 rst_a = 1'b0;
    step(); step();
    chk("idle_hold", 32'(sig_a), 32'h0);

    instr = 20'hE0821; start = 1'b1;              // ADD R1,R2,R3
    step(); start = 1'b0;
    chk("add_fetch", 32'(sig_a), 32'(F_LAST));
    step(); chk("add_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("add_execr", 32'(sig_a), 32'(EXR_ADD));
    step(); chk("add_aluwb", 32'(sig_a), 32'(WB_ADD));
    step(); chk("add_refetch", 32'(sig_a), 32'(F_LAST));

    instr = 20'hE2500; alu_flags = 4'b0100;       // SUBS R0,R0,#1
    step(); chk("subs_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("subs_execi", 32'(sig_a), 32'(EXI_SUB));
    step(); chk("subs_aluwb", 32'(sig_a), 32'(WB_SUBI));
    step(); chk("subs_fetch", 32'(sig_a), 32'(F_LAST));
    chk("subs_flags", 32'(u_a.u_cond.flags_q), 32'h4);

    instr = 20'h0A000; alu_flags = 4'b0000;       // BEQ
    step(); chk("beq_decode", 32'(sig_a), 32'(D_BR));
    step(); chk("beq_branch", 32'(sig_a), 32'(BR));
    step(); chk("beq_fetch", 32'(sig_a), 32'(F_LAST));

    instr = 20'h1A000;                            // BNE, not taken
    step(); chk("bne_decode", 32'(sig_a), 32'(D_BR));
    step(); chk("bne_skip", 32'(sig_a), 32'(F_LAST));

    instr = 20'hF0821;                            // cond 1111 never executes
    step(); chk("nv_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("nv_skip", 32'(sig_a), 32'(F_LAST));

    instr = 20'hE3500; alu_flags = 4'b0011;       // CMP R0,#0
    step(); chk("cmp_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("cmp_execi", 32'(sig_a), 32'(EXI_SUB));
    step(); chk("cmp_aluwb", 32'(sig_a), 32'(WB_CMPI));
    step(); chk("cmp_fetch", 32'(sig_a), 32'(F_LAST));
    chk("cmp_flags", 32'(u_a.u_cond.flags_q), 32'h3);

    instr = 20'hE0111; alu_flags = 4'b1011;       // ANDS R1,R1,R2
    step(); chk("ands1_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("ands1_execr", 32'(sig_a), 32'(EXR_AND));
    step(); chk("ands1_aluwb", 32'(sig_a), 32'(WB_AND));
    step(); chk("ands1_fetch", 32'(sig_a), 32'(F_LAST));
    chk("ands1_flags", 32'(u_a.u_cond.flags_q), 32'hB);

    alu_flags = 4'b0100;                          // NZ=01 taken, CV=11 kept
    step(); chk("ands2_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("ands2_execr", 32'(sig_a), 32'(EXR_AND));
    step(); chk("ands2_aluwb", 32'(sig_a), 32'(WB_AND));
    step(); chk("ands2_fetch", 32'(sig_a), 32'(F_LAST));
    chk("ands2_flags", 32'(u_a.u_cond.flags_q), 32'h7);

    instr = 20'hE082F; alu_flags = 4'b0000;       // ADD PC,R2,R3
    step(); chk("addpc_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("addpc_execr", 32'(sig_a), 32'(EXR_ADD));
    step(); chk("addpc_aluwb", 32'(sig_a), 32'(WB_ADDPC));
    step(); chk("addpc_fetch", 32'(sig_a), 32'(F_LAST));

    instr = 20'hE0221;                            // EOR: unsupported, no writeback
    step(); chk("eor_decode", 32'(sig_a), 32'(D_DP));
    step(); chk("eor_execr", 32'(sig_a), 32'(EXR_ADD));
    step(); chk("eor_aluwb", 32'(sig_a), 32'h1);
    step(); chk("eor_fetch", 32'(sig_a), 32'(F_LAST));
    chk("eor_flags", 32'(u_a.u_cond.flags_q), 32'h7);
    rst_a = 1'b1;

    // ---- instance B: MEM_WAIT=2 ----
    #1 rst_b = 1'b0;
    instr = 20'hE5C21; start = 1'b1;              // STRB R1,[R2,#4]
    step(); start = 1'b0;
    chk("strb_fetch0", 32'(sig_b), 32'(F_WAIT));
    step(); chk("strb_fetch1", 32'(sig_b), 32'(F_WAIT));
    step(); chk("strb_fetch2", 32'(sig_b), 32'(F_LAST));
    step(); chk("strb_decode", 32'(sig_b), 32'(D_ST));
    step(); chk("strb_memadr", 32'(sig_b), 32'(MA_ST));
    step(); chk("strb_memwr0", 32'(sig_b), 32'(MWB_WAIT));
    step(); chk("strb_memwr1", 32'(sig_b), 32'(MWB_WAIT));
    step(); chk("strb_memwr2", 32'(sig_b), 32'(MWB_LAST));
    step(); chk("strb_next_fetch", 32'(sig_b), 32'(F_WAIT));

    instr = 20'hE5D21;                            // LDRB R1,[R2]
    step(); chk("ldrb_fetch1", 32'(sig_b), 32'(F_WAIT));
    step(); chk("ldrb_fetch2", 32'(sig_b), 32'(F_LAST));
    step(); chk("ldrb_decode", 32'(sig_b), 32'(D_LD));
    step(); chk("ldrb_memadr", 32'(sig_b), 32'(MA_LD));
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("ldrb_memrd%0d", i), 32'(sig_b), 32'(MR_B));
    end
    step(); chk("ldrb_memwb", 32'(sig_b), 32'(MWB));
    step(); chk("ldrb_next_fetch", 32'(sig_b), 32'(F_WAIT));
    rst_b = 1'b1;

    // ---- instance C: MEM_WAIT=3, COND_EN=0 ----
    #1 rst_c = 1'b0;
    instr = 20'hE5821; start = 1'b1;              // STR R1,[R2]
    step(); start = 1'b0;
    chk("str_fetch0", 32'(sig_c), 32'(F_WAIT));
    step(); step();
    chk("str_fetch2", 32'(sig_c), 32'(F_WAIT));
    step(); chk("str_fetch3", 32'(sig_c), 32'(F_LAST));
    step(); chk("str_decode", 32'(sig_c), 32'(D_ST));
    step(); chk("str_memadr", 32'(sig_c), 32'(MA_ST));
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("str_memwr%0d", i), 32'(sig_c), 32'(MWW_WAIT));
    end
    step(); chk("str_memwr3", 32'(sig_c), 32'(MWW_LAST));
    #1 rst_c = 1'b1;
    #1 chk("rst_mid_memwrite", 32'(mw_c), 32'h0);
    chk("rst_mid_sig", 32'(sig_c), 32'h0);
    #1 rst_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk($sformatf("post_rst_idle%0d", i), 32'(sig_c), 32'h0);
    end

    instr = 20'h00821; alu_flags = 4'b0000; start = 1'b1;  // ADDEQ with Z=0
    step(); start = 1'b0;
    chk("noc_fetch0", 32'(sig_c), 32'(F_WAIT));
    step(); step(); step();
    chk("noc_fetch3", 32'(sig_c), 32'(F_LAST));
    step(); chk("noc_decode", 32'(sig_c), 32'(D_DP));
    step(); chk("noc_execr", 32'(sig_c), 32'(EXR_ADD));
    step(); chk("noc_aluwb", 32'(sig_c), 32'(WB_ADD));
    step(); chk("noc_fetch", 32'(sig_c), 32'(F_WAIT));
    rst_c = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
- Multi-cycle controller for the ARM core: a Moore FSM plus a condition unit that sequences FETCH/DECODE/EXECUTE/WRITEBACK over a shared memory port.
- Replaces the single-cycle controller. Adds programmable memory wait states, a start-gated idle state, a flags register and a compile-time conditional-execution switch.
- Drives the multi-cycle datapath muxes and enables. Consumes Instr[31:12] and ALUFlags.

Parameters:
- MEM_WAIT, 0, extra wait cycles inserted on every memory access (fetch, load, store); range 0..15.
- COND_EN, 1, 1 = honour cond field; 0 = every instruction treated as AL.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE
- Instr  in  20  Instr[31:12] from the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- ByteMem  out  1  byte access (LDRB/STRB)
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4
- ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24 branch
- RegSrc  out  2  [0] = Rn is PC(15) for branch, [1] = Rm is Rd for store
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset state:
  - FSM is in IDLE.
  - Flags register is 0000 and the wait counter is 0.
  - All enables and strobes are 0, and all selects are 0.
- IDLE: leave on start=1 to FETCH; otherwise hold.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PCWrite pulse high only in the last cycle of the access, i.e. after MEM_WAIT wait cycles.
  - The counter counts 0..MEM_WAIT and clears on exit. Next state is DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ImmSrc and RegSrc per op.
  - Evaluate the condition against the flags register.
  - Condition fails: go to FETCH with no side effects.
  - op=01: MEMADR. op=10: BRANCH. op=00 with I=funct[5]=0: EXECR. op=00 with I=1: EXECI.
  - op=11 is undefined and returns to FETCH.
- MEMADR: ALUSrcB=01, ImmSrc=01, ADD. Next is MEMRD if L=funct[0]=1, else MEMWR.
- MEMRD:
  - AdrSrc=1, ByteMem=funct[2].
  - Hold for MEM_WAIT+1 cycles, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWR:
  - AdrSrc=1, ByteMem=funct[2], RegSrc[1]=1.
  - MemWrite is high for exactly one cycle, the last wait cycle. Then FETCH.
- EXECR / EXECI:
  - ALUSrcB=00 (EXECR) or 01 with ImmSrc=00 (EXECI).
  - cmd=funct[4:1] maps as: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB).
  - Any other cmd forces ADD with no writeback. Next is ALUWB.
- ALUWB:
  - ResultSrc=00. RegWrite=1 unless cmd is CMP or unsupported.
  - If S=funct[0]: latch ALUFlags into the flags register. For AND/ORR only N and Z are updated; C and V are kept.
  - CMP always updates all four flags.
  - Rd=15 with RegWrite also asserts PCWrite.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=1, then FETCH.
- Loop behaviour: after each instruction the FSM returns to FETCH and never to IDLE; only reset returns to IDLE.
- Reset mid-operation: asynchronous; all outputs go to their reset values in the same cycle. No partial write may be issued after reset deasserts.
- COND_EN=0: the condition unit always passes. The flags register still updates.
- Conditions supported: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. 1111 evaluates as fail.

Decomposition:
- Package arm_mc_pkg holds:
  - state_t enum;
  - ALU op localparams;
  - op/cmd/cond codes;
  - ResultSrc/ALUSrcB encodings.
- Sub-module arm_cond_unit contains the flags register, the condition evaluation and the partial-update logic (flag_we, nz_only, cond_ex).

Test Plan:
- MEM_WAIT=0, reset then start=1, ADD R1,R2,R3 (E0821003) -> FETCH, DECODE, EXECR, ALUWB; RegWrite high in cycle 4; PCWrite once.
- MEM_WAIT=2, STRB (E5C21004) -> FETCH lasts 3 cycles; MEMWR asserts MemWrite=1 and ByteMem=1 for exactly 1 cycle, in its 3rd cycle.
- SUBS R0,R0,#1 with ALUFlags=0100, then BEQ -> flags register = 0100; BRANCH taken, PCWrite=1; BNE instead -> DECODE then FETCH, no PCWrite.
- ANDS with ALUFlags=1011 while flags=0011 -> flags=1011 (N and Z taken from ALUFlags; C=1, V=1 kept).
- Assert reset during MEMWR with MEM_WAIT=3 -> MemWrite=0 immediately; IDLE; busy=0; no write after release until start.
- COND_EN=0, cond=0000 while Z=0 -> instruction executes; RegWrite pulses.
